// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_state_e : opcode-word / immediate-word fetch phases
//   ImmFlagBit    : bit of the opcode word that flags a trailing immediate word
//   ifid_word_t   : instruction + immediate words carried in the IF/ID register
package fetch_pkg;

  typedef enum logic [0:0] {
    S_OP,
    S_IMM
  } fetch_state_e;

  localparam int unsigned ImmFlagBit = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
  } ifid_word_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset, loads RESET_VECTOR
//   load_i     : load load_val_i (redirect); wins over inc_i
//   load_val_i : redirect address
//   inc_i      : advance by one, wrapping modulo 2^ADDR_W
//   pc_o       : current PC
module pc_reg #(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_VECTOR;
    end else if (load_i) begin
      pc_q <= load_val_i;
    end else if (inc_i) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with optional one-word immediate extension.
// An opcode word with bit 0 set is followed by an immediate word at PC+1;
// such instructions are assembled over two cycles (one bubble) before issue.
// Optional feature macro FETCH_PERF_CNT_EN adds the perf_instr_cnt port.
//   clk            : clock, rising edge
//   rst            : synchronous active-low reset (priority over flush/stall)
//   stall          : hold PC, phase, held word and IF/ID
//   flush          : redirect to branch_target, drop any partial instruction
//   branch_target  : redirect PC
//   imem_addr      : instruction memory address (= PC)
//   imem_data      : combinational instruction memory read data
//   ifid_instr/ifid_imm/ifid_pc/ifid_valid : IF/ID register outputs
//   perf_instr_cnt : count of issued instructions (FETCH_PERF_CNT_EN only)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       ifid_instr,
  output logic [15:0]       ifid_imm,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_instr_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  ifid_word_t        ifid_q, ifid_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       held_word_q, held_word_d;
  logic [ADDR_W-1:0] held_pc_q, held_pc_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;

  pc_reg #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (pc_load),
    .load_val_i(branch_target),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  assign imem_addr = pc;

  always_comb begin
    state_d     = state_q;
    ifid_d      = ifid_q;
    ifid_pc_d   = ifid_pc_q;
    valid_d     = valid_q;
    held_word_d = held_word_q;
    held_pc_d   = held_pc_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;

    if (flush) begin
      // Redirect drops any half-assembled instruction.
      state_d      = S_OP;
      valid_d      = 1'b0;
      ifid_d.instr = '0;
      ifid_d.imm   = '0;
      held_word_d  = '0;
      pc_load      = 1'b1;
    end else if (!stall) begin
      pc_inc = 1'b1;
      unique case (state_q)
        S_OP: begin
          if (imem_data[ImmFlagBit]) begin
            held_word_d = imem_data;
            held_pc_d   = pc;
            valid_d     = 1'b0;
            state_d     = S_IMM;
          end else begin
            ifid_d.instr = imem_data;
            ifid_d.imm   = '0;
            ifid_pc_d    = pc;
            valid_d      = 1'b1;
          end
        end
        S_IMM: begin
          ifid_d.instr = held_word_q;
          ifid_d.imm   = imem_data;
          ifid_pc_d    = held_pc_q;
          valid_d      = 1'b1;
          state_d      = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_OP;
      ifid_q      <= '0;
      ifid_pc_q   <= '0;
      valid_q     <= 1'b0;
      held_word_q <= '0;
      held_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      ifid_q      <= ifid_d;
      ifid_pc_q   <= ifid_pc_d;
      valid_q     <= valid_d;
      held_word_q <= held_word_d;
      held_pc_q   <= held_pc_d;
    end
  end

  assign ifid_instr = ifid_q.instr;
  assign ifid_imm   = ifid_q.imm;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic        issue;
  logic [31:0] perf_cnt_q;

  // An instruction issues when IF/ID is freshly loaded with a complete word pair.
  assign issue = !flush && !stall && ((state_q == S_IMM) || !imem_data[ImmFlagBit]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt_q <= '0;
    end else if (issue) begin
      perf_cnt_q <= perf_cnt_q + 32'd1;
    end
  end

  assign perf_instr_cnt = perf_cnt_q;
`endif

endmodule
